// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding definitions: instruction classes, opcodes, immediate
// limits and field-packing helpers. Reused by the encoder and the decoder.
package rv32i_pkg;

  typedef enum logic [3:0] {
    CLS_LOAD   = 4'd0,
    CLS_OPIMM  = 4'd1,
    CLS_AUIPC  = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_OP     = 4'd4,
    CLS_LUI    = 4'd5,
    CLS_BRANCH = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_JAL    = 4'd8,
    CLS_XORID  = 4'd9
  } class_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_XORID  = 7'b0001011;

  localparam logic signed [31:0] IMM_I_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM_I_MAX =  32'sd2047;
  localparam logic signed [31:0] IMM_B_MIN = -32'sd4096;
  localparam logic signed [31:0] IMM_B_MAX =  32'sd4094;
  localparam logic signed [31:0] IMM_J_MIN = -32'sd1048576;
  localparam logic signed [31:0] IMM_J_MAX =  32'sd1048574;

  function automatic logic in_range(input logic signed [31:0] v,
                                    input logic signed [31:0] lo,
                                    input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic [31:0] enc_r(input logic f7b, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {1'b0, f7b, 5'b00000, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
  endfunction

  function automatic logic [31:0] enc_u(input logic [31:12] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bus of the instruction encoder; master drives requests
// and out_ready, slave (the encoder) drives in_ready and the encoded beat.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Class;
  logic [2:0]  Funct3;
  logic        Funct7;
  logic [4:0]  Rd;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic [31:0] Imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Instr;
  logic [31:0] Addr;
  logic        Err;

  modport master (
    output in_valid, Class, Funct3, Funct7, Rd, Rs1, Rs2, Imm, out_ready,
    input  in_ready, out_valid, Instr, Addr, Err
  );

  modport slave (
    input  in_valid, Class, Funct3, Funct7, Rd, Rs1, Rs2, Imm, out_ready,
    output in_ready, out_valid, Instr, Addr, Err
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I field packing and legality check.
// XORID_EN: when defined, class XORID encodes as a custom R-type (Funct3=100).
module instr_pack
  import rv32i_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        illegal
);

  logic [31:0] raw;
  logic        bad;

  always_comb begin
    raw = '0;
    bad = 1'b0;
    case (class_e'(cls))
      CLS_LOAD: begin
        bad = !in_range(imm, IMM_I_MIN, IMM_I_MAX) ||
              (funct3 inside {3'b011, 3'b110, 3'b111});
        raw = enc_i(imm[11:0], rs1, funct3, rd, OPC_LOAD);
      end
      CLS_OPIMM: begin
        // Shift-immediates carry the shift type in instr[30] and a 5-bit shamt.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          bad = (imm[31:5] != '0) || (funct7 && funct3 != 3'b101);
          raw = enc_i({1'b0, funct7, 5'b00000, imm[4:0]}, rs1, funct3, rd, OPC_OPIMM);
        end else begin
          bad = !in_range(imm, IMM_I_MIN, IMM_I_MAX) || funct7;
          raw = enc_i(imm[11:0], rs1, funct3, rd, OPC_OPIMM);
        end
      end
      CLS_AUIPC: begin
        bad = (imm[11:0] != '0);
        raw = enc_u(imm[31:12], rd, OPC_AUIPC);
      end
      CLS_STORE: begin
        bad = !in_range(imm, IMM_I_MIN, IMM_I_MAX) || (funct3 > 3'b010);
        raw = enc_s(imm[11:0], rs2, rs1, funct3, OPC_STORE);
      end
      CLS_OP: begin
        bad = funct7 && !(funct3 inside {3'b000, 3'b101});
        raw = enc_r(funct7, rs2, rs1, funct3, rd, OPC_OP);
      end
      CLS_LUI: begin
        bad = (imm[11:0] != '0);
        raw = enc_u(imm[31:12], rd, OPC_LUI);
      end
      CLS_BRANCH: begin
        bad = imm[0] || !in_range(imm, IMM_B_MIN, IMM_B_MAX) ||
              (funct3 inside {3'b010, 3'b011});
        raw = enc_b(imm[12:1], rs2, rs1, funct3, OPC_BRANCH);
      end
      CLS_JALR: begin
        bad = !in_range(imm, IMM_I_MIN, IMM_I_MAX) || (funct3 != 3'b000);
        raw = enc_i(imm[11:0], rs1, funct3, rd, OPC_JALR);
      end
      CLS_JAL: begin
        bad = imm[0] || !in_range(imm, IMM_J_MIN, IMM_J_MAX);
        raw = enc_j(imm[20:1], rd, OPC_JAL);
      end
`ifdef XORID_EN
      CLS_XORID: begin
        bad = (funct3 != 3'b100);
        raw = enc_r(funct7, rs2, rs1, funct3, rd, OPC_XORID);
      end
`endif
      default: bad = 1'b1;
    endcase
  end

  assign illegal = bad;
  assign instr   = bad ? '0 : raw;

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: one-deep output stage with valid/ready handshake,
// address counter and saturating illegal-request counter. Honors XORID_EN.
module instr_encoder
  import rv32i_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus,
  output logic [7:0]      err_count
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e      state, state_nxt;
  logic        accept, complete;
  logic [31:0] pack_instr;
  logic        pack_illegal;
  logic [31:0] instr_q, addr_q;
  logic        err_q;

  instr_pack u_pack (
    .cls     (bus.Class),
    .funct3  (bus.Funct3),
    .funct7  (bus.Funct7),
    .rd      (bus.Rd),
    .rs1     (bus.Rs1),
    .rs2     (bus.Rs2),
    .imm     (bus.Imm),
    .instr   (pack_instr),
    .illegal (pack_illegal)
  );

  assign bus.in_ready  = !rst && ((state == EMPTY) || bus.out_ready);
  assign bus.out_valid = (state == FULL);
  assign bus.Instr     = instr_q;
  assign bus.Addr      = addr_q;
  assign bus.Err       = err_q;

  always_comb begin
    accept    = bus.in_valid && bus.in_ready;
    complete  = (state == FULL) && bus.out_ready;
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (complete && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Addr tracks the beat currently presented; it only moves past legal beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= '0;
      err_q     <= 1'b0;
      addr_q    <= BASE_ADDR;
      err_count <= '0;
    end else begin
      if (complete && !err_q)
        addr_q <= addr_q + 32'd4;
      if (accept) begin
        instr_q <= pack_instr;
        err_q   <= pack_illegal;
        if (pack_illegal && err_count != 8'hFF)
          err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed requests push hand-computed
// expected beats; a monitor pops and compares every completed output beat.
module tb_instr_encoder;
  import rv32i_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] err_count;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic [31:0] exp_addr;

  instr_encoder_if bus ();

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed beat must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got instr %h with empty scoreboard", bus.Instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("instr", bus.Instr, e.instr);
        chk("addr", bus.Addr, e.addr);
        chk("err", {31'b0, bus.Err}, {31'b0, e.err});
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] ei, input logic ee);
    logic got;
    int   n;
    exp_t e;
    bus.Class = c; bus.Funct3 = f3; bus.Funct7 = f7;
    bus.Rd = rd; bus.Rs1 = rs1; bus.Rs2 = rs2; bus.Imm = imm;
    bus.in_valid = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk);
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 for instr %h", ei);
    end else begin
      e.instr = ei;
      e.addr  = exp_addr;
      e.err   = ee;
      sb.push_back(e);
      if (!ee) exp_addr = exp_addr + 32'd4;
    end
    #1;
    if (got) chk("latency_out_valid", {31'b0, bus.out_valid}, 32'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.Class = '0; bus.Funct3 = '0; bus.Funct7 = 1'b0;
    bus.Rd = '0; bus.Rs1 = '0; bus.Rs2 = '0; bus.Imm = '0;
    exp_addr = BASE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_instr", bus.Instr, 32'd0);
    chk("rst_err", {31'b0, bus.Err}, 32'd0);
    chk("rst_addr", bus.Addr, BASE);
    chk("rst_err_count", {24'b0, err_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    send(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    idle();
    drain();

    // back-to-back OP then BRANCH
    send(4'd4, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b0);
    send(4'd6, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4, 32'hFE20_8EE3, 1'b0);
    send(4'd8, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h0080_00EF, 1'b0);
    send(4'd8, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7, 32'h0000_0000, 1'b1);
    idle();
    drain();
    chk("err_count_after_jal7", {24'b0, err_count}, 32'd1);

    send(4'd5, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_5137, 1'b0);
    send(4'd0, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, -32'sd1, 32'hFFF1_2283, 1'b0);
    send(4'd3, 3'b010, 1'b0, 5'd0, 5'd2, 5'd5, 32'd2047, 32'h7E51_2FA3, 1'b0);
    send(4'd1, 3'b000, 1'b0, 5'd1, 5'd1, 5'd0, 32'd2048, 32'h0, 1'b1);
    send(4'd3, 3'b011, 1'b0, 5'd0, 5'd2, 5'd5, 32'd0, 32'h0, 1'b1);
    send(4'd6, 3'b001, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4094, 32'h7E00_1FE3, 1'b0);
    send(4'd6, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4096, 32'h0, 1'b1);
    send(4'd1, 3'b101, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030_D093, 1'b0);
    send(4'd1, 3'b001, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32, 32'h0, 1'b1);
    send(4'd2, 3'b000, 1'b0, 5'd4, 5'd0, 5'd0, 32'h0000_1001, 32'h0, 1'b1);
    send(4'd2, 3'b000, 1'b0, 5'd4, 5'd0, 5'd0, 32'hFFFF_F000, 32'hFFFF_F217, 1'b0);
    send(4'd7, 3'b000, 1'b0, 5'd1, 5'd5, 5'd0, -32'sd2048, 32'h8002_80E7, 1'b0);
    send(4'd15, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0, 1'b1);
`ifdef XORID_EN
    send(4'd9, 3'b100, 1'b0, 5'd5, 5'd6, 5'd7, 32'd0, 32'h0073_428B, 1'b0);
`else
    send(4'd9, 3'b100, 1'b0, 5'd5, 5'd6, 5'd7, 32'd0, 32'h0, 1'b1);
`endif
    idle();
    drain();
`ifdef XORID_EN
    chk("err_count_total", {24'b0, err_count}, 32'd7);
`else
    chk("err_count_total", {24'b0, err_count}, 32'd8);
`endif

    // Backpressure: first word held, second blocked until out_ready rises.
    begin
      logic [31:0] held_addr;
      bus.out_ready = 1'b0;
      held_addr = exp_addr;
      send(4'd4, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0031_00B3, 1'b0);
      bus.Class = 4'd1; bus.Funct3 = 3'b000; bus.Funct7 = 1'b0;
      bus.Rd = 5'd2; bus.Rs1 = 5'd0; bus.Rs2 = 5'd0; bus.Imm = 32'd1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("hold_instr", bus.Instr, 32'h0031_00B3);
        chk("hold_addr", bus.Addr, held_addr);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      send(4'd1, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd1, 32'h0010_0113, 1'b0);
      idle();
      drain();
    end

    // Reset while FULL discards the pending word.
    bus.out_ready = 1'b0;
    send(4'd1, 3'b000, 1'b0, 5'd3, 5'd0, 5'd0, 32'd2, 32'h0020_0193, 1'b0);
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    exp_addr = BASE;
    @(posedge clk); #1;
    chk("rst_full_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_full_err_count", {24'b0, err_count}, 32'd0);
    chk("rst_full_addr", bus.Addr, BASE);
    @(negedge clk);
    chk("rst_full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    idle();
    drain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, SHALL be the byte address given to the first emitted word after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 in_valid  input  1  SHALL mark that the request fields below are valid.
REQ-005 in_ready  output  1  SHALL signal that the block accepts a request this cycle.
REQ-006 Class  input  4  SHALL select the instruction class: LOAD, OPIMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, XORID.
REQ-007 Funct3  input  3; Funct7  input  1 (maps to instr[30]); Rd, Rs1, Rs2  input  5 each; Imm  input  32 (signed, byte offset) SHALL carry the instruction fields.
REQ-008 out_valid  output  1; out_ready  input  1 SHALL form the output handshake.
REQ-009 Instr  output  32  SHALL carry the encoded RV32I word.
REQ-010 Addr  output  32  SHALL carry the byte address of Instr.
REQ-011 Err  output  1  SHALL flag that the current output beat is an illegal request.
REQ-012 err_count  output  8  SHALL count illegal requests, saturating at 255.

Function
REQ-013 A request SHALL be accepted when in_valid and in_ready are both high; an output beat SHALL complete when out_valid and out_ready are both high.
REQ-014 The output stage SHALL be a two-state FSM. EMPTY -> FULL on accept. FULL -> EMPTY on output completion with no accept. FULL -> FULL on output completion with a simultaneous accept.
REQ-015 in_ready SHALL equal (state==EMPTY) or out_ready, so that back-to-back accepts sustain one word per cycle.
REQ-016 Latency SHALL be one cycle: a word accepted in cycle N is presented with out_valid=1 in cycle N+1.
REQ-017 Instr, Addr and Err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 Opcodes SHALL be:
- LOAD 0000011, OPIMM 0010011, AUIPC 0010111, STORE 0100011, OP 0110011
- LUI 0110111, BRANCH 1100011, JALR 1100111, JAL 1101111, XORID 0001011
REQ-019 Field packing SHALL follow the standard RV32I I/S/B/U/J/R formats; for B and J, Imm bit 0 is dropped.
REQ-020 Illegal requests SHALL be any of:
- I/S-type Imm outside -2048..2047
- B-type Imm odd or outside -4096..4094; J-type Imm odd or outside ±1 MiB
- U-type Imm[11:0] nonzero
- LOAD Funct3 in {011,110,111}; STORE Funct3 > 010; BRANCH Funct3 in {010,011}; JALR Funct3 != 000
- Funct7=1 on OP with Funct3 not in {000,101}, or on OPIMM with Funct3 != 101
- shift-immediate Imm[31:5] nonzero
- undefined Class
REQ-021 An illegal request SHALL be consumed and produce a beat with Instr=0 and Err=1; Addr SHALL NOT advance on completion of that beat.
REQ-022 On completion of each legal beat, Addr SHALL advance by 4, wrapping modulo 2^32.
REQ-023 err_count SHALL increment once per illegal request, on accept.

Reset
REQ-024 While rst=1 the block SHALL set: state=EMPTY, out_valid=0, Instr=0, Err=0, Addr=BASE_ADDR, err_count=0. in_ready SHALL read 0 during reset.
REQ-025 A reset asserted while FULL SHALL discard the pending word with no completion; the first word after reset SHALL use BASE_ADDR.

Configuration
REQ-026 Macro XORID_EN defined: Class XORID SHALL encode as opcode 0001011, Funct3 100, R-type fields; any other Funct3 is illegal.
REQ-027 Macro XORID_EN undefined: Class XORID SHALL be illegal per REQ-021.

Structure
REQ-028 The Class enum, the opcode constants and the immediate range limits SHALL live in shared package rv32i_pkg, reused by the decoder.
REQ-029 Pure field packing and legality checking SHALL be combinational sub-module instr_pack; the handshake FSM and counters SHALL live in instr_encoder.

Verification
REQ-030 Reset, out_ready=1: OPIMM Funct3=000 Rd=1 Rs1=0 Imm=5 -> next cycle Instr=0x00500093, Addr=BASE_ADDR, Err=0.
REQ-031 OP Funct3=000 Funct7=1 Rd=3 Rs1=1 Rs2=2, then BRANCH Funct3=000 Rs1=1 Rs2=2 Imm=-4, back-to-back -> 0x402081B3 then 0xFE208EE3, with Addr +0 then +4.
REQ-032 JAL Rd=1 Imm=8 -> 0x008000EF; JAL Imm=7 -> Err=1, Instr=0, Addr unchanged, err_count=1.
REQ-033 out_ready=0, two requests presented -> first held stable, in_ready=0 thereafter; raise out_ready -> both words emitted in order, none lost or duplicated.
REQ-034 rst pulse while FULL -> out_valid=0 next cycle, err_count=0; next word at BASE_ADDR.
REQ-035 XORID Funct3=100 Rd=5 Rs1=6 Rs2=7 -> 0x007342 8B when XORID_EN is defined, i.e. 0x0073428B; Err=1 when it is undefined.
